// File: rtl/pipe_trap_ctrl_pkg.sv
// Shared types and constants for the pipeline trap/redirect sequencer.
// Carries the XLEN/PC widths and the FSM state encoding used by RTL and bench.
package pipe_trap_ctrl_pkg;

  localparam int XLEN     = 64;
  localparam int PC_WIDTH = 32;
  localparam int REG_IDX_W = 5;

  // Encoding is fixed so the debug state can be compared numerically.
  typedef enum logic [1:0] {
    CTRL_ST_RUN   = 2'd0,
    CTRL_ST_DRAIN = 2'd1,
    CTRL_ST_REDIR = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
  } pipe_ctl_t;

  localparam pipe_ctl_t PIPE_CTL_NONE = '{default: 1'b0};

  function automatic logic src_hit(
    input logic                 ren,
    input logic [REG_IDX_W-1:0] src_idx,
    input logic [REG_IDX_W-1:0] rd_idx
  );
    return ren && (src_idx == rd_idx);
  endfunction

endpackage

// File: rtl/pipe_trap_ctrl_if.sv
// Signal bundle between the pipeline stages and the trap sequencer.
// redirect_valid_o is a single-cycle strobe with no ready: IF must load redirect_pc_o in that cycle.
interface pipe_trap_ctrl_if;
  import pipe_trap_ctrl_pkg::*;

  logic                 wb_trap_i;
  logic [XLEN-1:0]      wb_trap_handle_pc_i;
  logic                 ex_branch_taken_i;
  logic [PC_WIDTH-1:0]  ex_branch_target_i;
  logic                 ex_load_i;
  logic [REG_IDX_W-1:0] ex_rd_idx_i;
  logic                 id_rs1_ren_i;
  logic [REG_IDX_W-1:0] id_rs1_idx_i;
  logic                 id_rs2_ren_i;
  logic [REG_IDX_W-1:0] id_rs2_idx_i;
  logic                 lsu_busy_i;

  logic                 stall_if_o;
  logic                 stall_id_o;
  logic                 flush_id_o;
  logic                 flush_ex_o;
  logic                 flush_mem_o;
  logic                 redirect_valid_o;
  logic [PC_WIDTH-1:0]  redirect_pc_o;
  logic                 drain_err_o;
  ctrl_state_e          dbg_state;

  // Pipeline side: produces stage status, consumes controls.
  modport master (
    output wb_trap_i, wb_trap_handle_pc_i, ex_branch_taken_i, ex_branch_target_i,
           ex_load_i, ex_rd_idx_i, id_rs1_ren_i, id_rs1_idx_i, id_rs2_ren_i,
           id_rs2_idx_i, lsu_busy_i,
    input  stall_if_o, stall_id_o, flush_id_o, flush_ex_o, flush_mem_o,
           redirect_valid_o, redirect_pc_o, drain_err_o, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  wb_trap_i, wb_trap_handle_pc_i, ex_branch_taken_i, ex_branch_target_i,
           ex_load_i, ex_rd_idx_i, id_rs1_ren_i, id_rs1_idx_i, id_rs2_ren_i,
           id_rs2_idx_i, lsu_busy_i,
    output stall_if_o, stall_id_o, flush_id_o, flush_ex_o, flush_mem_o,
           redirect_valid_o, redirect_pc_o, drain_err_o, dbg_state
  );

endinterface

// File: rtl/ld_use_hazard.sv
// Pure load-use comparator: the instruction in ID reads the rd of a load still in EX.
// Kept standalone so decode can reuse it; x0 never creates a hazard.
module ld_use_hazard
  import pipe_trap_ctrl_pkg::*;
(
  input  logic                 ex_load_i,
  input  logic [REG_IDX_W-1:0] ex_rd_idx_i,
  input  logic                 id_rs1_ren_i,
  input  logic [REG_IDX_W-1:0] id_rs1_idx_i,
  input  logic                 id_rs2_ren_i,
  input  logic [REG_IDX_W-1:0] id_rs2_idx_i,
  output logic                 ld_use_o
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_live  = ex_load_i && (ex_rd_idx_i != '0);
  assign rs1_hit  = src_hit(id_rs1_ren_i, id_rs1_idx_i, ex_rd_idx_i);
  assign rs2_hit  = src_hit(id_rs2_ren_i, id_rs2_idx_i, ex_rd_idx_i);
  assign ld_use_o = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_trap_ctrl.sv
// Pipeline sequencer: turns WB traps, EX branches and load-use hazards into stall/flush
// controls and a single IF redirect, draining an in-flight LSU access before a trap redirect.
module pipe_trap_ctrl
  import pipe_trap_ctrl_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  pipe_trap_ctrl_if.slave  bus
);

  ctrl_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] trap_pc_q, trap_pc_d;
  logic                err_q, err_d;

  pipe_ctl_t           ctl;
  logic                redir_valid;
  logic [PC_WIDTH-1:0] redir_pc;
  logic                ld_use;
  logic                drain_timeout;
  logic                unused_pc_hi;

  // Only the low PC_WIDTH bits of the handler PC are fetchable.
  assign unused_pc_hi  = ^bus.wb_trap_handle_pc_i[XLEN-1:PC_WIDTH];
  assign drain_timeout = (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1));

  ld_use_hazard u_ld_use_hazard (
    .ex_load_i    (bus.ex_load_i),
    .ex_rd_idx_i  (bus.ex_rd_idx_i),
    .id_rs1_ren_i (bus.id_rs1_ren_i),
    .id_rs1_idx_i (bus.id_rs1_idx_i),
    .id_rs2_ren_i (bus.id_rs2_ren_i),
    .id_rs2_idx_i (bus.id_rs2_idx_i),
    .ld_use_o     (ld_use)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= CTRL_ST_RUN;
      cnt_q     <= '0;
      trap_pc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trap_pc_q <= trap_pc_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trap_pc_d   = trap_pc_q;
    err_d       = err_q;
    ctl         = PIPE_CTL_NONE;
    redir_valid = 1'b0;
    redir_pc    = '0;

    unique case (state_q)
      CTRL_ST_RUN: begin
        if (bus.wb_trap_i) begin
          // Trap wins over branch and hazard: everything younger is discarded anyway.
          trap_pc_d     = bus.wb_trap_handle_pc_i[PC_WIDTH-1:0];
          ctl.stall_if  = 1'b1;
          ctl.flush_id  = 1'b1;
          ctl.flush_ex  = 1'b1;
          ctl.flush_mem = 1'b1;
          if (bus.lsu_busy_i) begin
            state_d = CTRL_ST_DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = CTRL_ST_REDIR;
          end
        end else if (bus.ex_branch_taken_i) begin
          redir_valid  = 1'b1;
          redir_pc     = bus.ex_branch_target_i;
          ctl.flush_id = 1'b1;
          ctl.flush_ex = 1'b1;
        end else if (ld_use) begin
          ctl.stall_if = 1'b1;
          ctl.stall_id = 1'b1;
          ctl.flush_ex = 1'b1;
        end
      end

      CTRL_ST_DRAIN: begin
        // MEM is left alone so the outstanding bus access can retire.
        ctl.stall_if = 1'b1;
        ctl.flush_id = 1'b1;
        ctl.flush_ex = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (!bus.lsu_busy_i || drain_timeout) begin
          state_d = CTRL_ST_REDIR;
        end
        if (bus.lsu_busy_i && drain_timeout) begin
          err_d = 1'b1;
        end
      end

      CTRL_ST_REDIR: begin
        redir_valid   = 1'b1;
        redir_pc      = trap_pc_q;
        ctl.flush_id  = 1'b1;
        ctl.flush_ex  = 1'b1;
        ctl.flush_mem = 1'b1;
        state_d       = CTRL_ST_RUN;
      end

      default: begin
        state_d = CTRL_ST_RUN;
      end
    endcase
  end

  assign bus.stall_if_o       = ctl.stall_if;
  assign bus.stall_id_o       = ctl.stall_id;
  assign bus.flush_id_o       = ctl.flush_id;
  assign bus.flush_ex_o       = ctl.flush_ex;
  assign bus.flush_mem_o      = ctl.flush_mem;
  assign bus.redirect_valid_o = redir_valid;
  assign bus.redirect_pc_o    = redir_pc;
  assign bus.drain_err_o      = err_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_pipe_trap_ctrl.sv
// Self-checking bench for pipe_trap_ctrl: expected output vectors are queued as stimulus is
// driven and compared mid-cycle against the DUT's combinational outputs.
module tb_pipe_trap_ctrl;
  import pipe_trap_ctrl_pkg::*;

  localparam int W = 41;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  logic clk;
  logic rst_n;
  pipe_trap_ctrl_if bus();

  logic [W-1:0] exp_q[$];
  int n_tests;
  int n_fail;
  logic err_m;

  pipe_trap_ctrl #(.DRAIN_TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(logic sif, logic sid, logic fid, logic fex, logic fmem,
                                      logic rv, logic [31:0] pc, logic err, logic [1:0] st);
    return {sif, sid, fid, fex, fmem, rv, pc, err, st};
  endfunction

  function automatic logic [W-1:0] outs();
    return {bus.stall_if_o, bus.stall_id_o, bus.flush_id_o, bus.flush_ex_o, bus.flush_mem_o,
            bus.redirect_valid_o, bus.redirect_pc_o, bus.drain_err_o, 2'(bus.dbg_state)};
  endfunction

  task automatic idle();
    bus.wb_trap_i           = 1'b0;
    bus.wb_trap_handle_pc_i = '0;
    bus.ex_branch_taken_i   = 1'b0;
    bus.ex_branch_target_i  = '0;
    bus.ex_load_i           = 1'b0;
    bus.ex_rd_idx_i         = '0;
    bus.id_rs1_ren_i        = 1'b0;
    bus.id_rs1_idx_i        = '0;
    bus.id_rs2_ren_i        = 1'b0;
    bus.id_rs2_idx_i        = '0;
    bus.lsu_busy_i          = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] got, exp;
    rst_n = 1'b0;
    idle();
    err_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 1'b0, S_RUN));
    exp = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_held: got %h exp %h", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 1'b0, S_RUN));
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_idle[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_load_use();
    logic [W-1:0] got, exp;
    logic hz;
    // Directed: rs1 hit, idle, rd=x0, rs2 hit, rs2 hit without ren, non-load.
    for (int i = 0; i < 6; i++) begin
      next_cycle(); idle();
      hz = 1'b0;
      case (i)
        0: begin bus.ex_load_i = 1; bus.ex_rd_idx_i = 5; bus.id_rs1_ren_i = 1; bus.id_rs1_idx_i = 5; hz = 1; end
        1: ;
        2: begin bus.ex_load_i = 1; bus.ex_rd_idx_i = 0; bus.id_rs1_ren_i = 1; bus.id_rs1_idx_i = 0; end
        3: begin bus.ex_load_i = 1; bus.ex_rd_idx_i = 9; bus.id_rs2_ren_i = 1; bus.id_rs2_idx_i = 9; hz = 1; end
        4: begin bus.ex_load_i = 1; bus.ex_rd_idx_i = 9; bus.id_rs2_ren_i = 0; bus.id_rs2_idx_i = 9; end
        default: begin bus.ex_load_i = 0; bus.ex_rd_idx_i = 7; bus.id_rs1_ren_i = 1; bus.id_rs1_idx_i = 7; end
      endcase
      exp_q.push_back(mk(hz, hz, 0, hz, 0, 0, 32'h0, err_m, S_RUN));
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL load_use[%0d]: got %h exp %h", i, got, exp); end
    end
    // Random indices from a small range so hits are frequent.
    for (int i = 0; i < 24; i++) begin
      logic ld, r1en, r2en;
      logic [4:0] rd, r1, r2;
      next_cycle(); idle();
      ld = 1'($urandom_range(0, 1)); r1en = 1'($urandom_range(0, 1)); r2en = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
      bus.ex_load_i = ld; bus.ex_rd_idx_i = rd;
      bus.id_rs1_ren_i = r1en; bus.id_rs1_idx_i = r1;
      bus.id_rs2_ren_i = r2en; bus.id_rs2_idx_i = r2;
      hz = ld && (rd != 0) && ((r1en && r1 == rd) || (r2en && r2 == rd));
      exp_q.push_back(mk(hz, hz, 0, hz, 0, 0, 32'h0, err_m, S_RUN));
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL load_use_rand[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_branch();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle();
      case (i)
        0: begin
          bus.ex_branch_taken_i = 1; bus.ex_branch_target_i = 32'h8000_0100;
          exp_q.push_back(mk(0, 0, 1, 1, 0, 1, 32'h8000_0100, err_m, S_RUN));
        end
        1: begin // branch beats a simultaneous load-use hazard
          bus.ex_branch_taken_i = 1; bus.ex_branch_target_i = 32'h0000_0044;
          bus.ex_load_i = 1; bus.ex_rd_idx_i = 3; bus.id_rs1_ren_i = 1; bus.id_rs1_idx_i = 3;
          exp_q.push_back(mk(0, 0, 1, 1, 0, 1, 32'h0000_0044, err_m, S_RUN));
        end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, err_m, S_RUN));
      endcase
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL branch[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_trap_idle();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle();
      case (i)
        0: begin // upper handler bits must be dropped; branch and hazard ignored
          bus.wb_trap_i = 1; bus.wb_trap_handle_pc_i = 64'hDEAD_BEEF_8000_0000;
          bus.ex_branch_taken_i = 1; bus.ex_branch_target_i = 32'h1111_2222;
          bus.ex_load_i = 1; bus.ex_rd_idx_i = 4; bus.id_rs1_ren_i = 1; bus.id_rs1_idx_i = 4;
          exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 32'h0, err_m, S_RUN));
        end
        1: begin // REDIR ignores a new trap and a branch
          bus.wb_trap_i = 1; bus.wb_trap_handle_pc_i = 64'h0000_0000_3333_3333;
          bus.ex_branch_taken_i = 1; bus.ex_branch_target_i = 32'h4444_4444;
          exp_q.push_back(mk(0, 0, 1, 1, 1, 1, 32'h8000_0000, err_m, S_REDIR));
        end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, err_m, S_RUN));
      endcase
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL trap_idle[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      next_cycle(); idle();
      case (i)
        0: begin bus.wb_trap_i = 1; bus.wb_trap_handle_pc_i = 64'h0000_0000_0000_1000;
                 exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 32'h0, err_m, S_RUN)); end
        1: exp_q.push_back(mk(0, 0, 1, 1, 1, 1, 32'h0000_1000, err_m, S_REDIR));
        2: begin bus.wb_trap_i = 1; bus.wb_trap_handle_pc_i = 64'h0000_0000_0000_2004;
                 exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 32'h0, err_m, S_RUN)); end
        3: exp_q.push_back(mk(0, 0, 1, 1, 1, 1, 32'h0000_2004, err_m, S_REDIR));
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, err_m, S_RUN));
      endcase
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_trap_busy();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 6; i++) begin
      next_cycle(); idle();
      case (i)
        0: begin bus.wb_trap_i = 1; bus.wb_trap_handle_pc_i = 64'h0000_0001_8000_0200; bus.lsu_busy_i = 1;
                 exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 32'h0, err_m, S_RUN)); end
        1, 2: begin bus.lsu_busy_i = 1;
                 exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 32'h0, err_m, S_DRAIN)); end
        3: begin bus.wb_trap_i = 1; bus.ex_branch_taken_i = 1; bus.ex_branch_target_i = 32'h5555_0000;
                 exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 32'h0, err_m, S_DRAIN)); end
        4: exp_q.push_back(mk(0, 0, 1, 1, 1, 1, 32'h8000_0200, err_m, S_REDIR));
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, err_m, S_RUN));
      endcase
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL trap_busy[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] got, exp;
    // 1 trap cycle, 16 DRAIN cycles, 1 REDIR, 2 RUN.
    for (int i = 0; i < 20; i++) begin
      next_cycle(); idle();
      bus.lsu_busy_i = 1'b1;
      if (i == 0) begin
        bus.wb_trap_i = 1; bus.wb_trap_handle_pc_i = 64'h0000_0000_0000_0180;
        exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 32'h0, err_m, S_RUN));
      end else if (i <= 16) begin
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 32'h0, err_m, S_DRAIN));
      end else if (i == 17) begin
        err_m = 1'b1;
        exp_q.push_back(mk(0, 0, 1, 1, 1, 1, 32'h0000_0180, err_m, S_REDIR));
      end else begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, err_m, S_RUN));
      end
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL timeout[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle();
      bus.lsu_busy_i = 1'b1;
      if (i == 0) begin
        bus.wb_trap_i = 1; bus.wb_trap_handle_pc_i = 64'h0000_0000_0000_0300;
        exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 32'h0, err_m, S_RUN));
      end else begin
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 32'h0, err_m, S_DRAIN));
      end
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rst_drain_pre[%0d]: got %h exp %h", i, got, exp); end
    end
    // Asynchronous assertion mid-cycle while still in DRAIN; sticky error clears too.
    next_cycle();
    idle();
    rst_n = 1'b0;
    err_m = 1'b0;
    #2;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, err_m, S_RUN));
    exp = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_drain_async: got %h exp %h", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, err_m, S_RUN));
      @(negedge clk); exp = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rst_drain_post[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    err_m   = 1'b0;
    rst_n   = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_trap_idle();
    test_back_to_back();
    test_trap_busy();
    test_timeout();
    test_reset_mid_drain();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
